// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, FSM state type and queue entry type for the instruction fetch unit
package fetch_pkg;

    localparam int          FETCH_ADDR_W   = 5;
    localparam int          FETCH_DEPTH    = 2;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0;

    typedef enum logic {
        FETCH,
        STALL
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction queue of {pc, inst} entries with push, pop, flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output logic          valid,
    output entry_t        dout,
    output logic [CW-1:0] count
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    entry_t        q [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid  = count != '0;
    assign do_pop = pop && valid;
    assign dout   = valid ? q[rp] : '0;

    // Pointers and occupancy; flush empties the queue and wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= nxt(wp);
            if (do_pop)
                rp <= nxt(rp);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Entry storage needs no reset because dout is masked while the queue is empty
    always_ff @(posedge clk) begin
        if (push && !flush)
            q[wp] <= din;
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-serial instruction fetch assembling big-endian words into a small queue
module imem_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = FETCH_ADDR_W,
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(DEPTH + 3);

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [31:0]   fetch_pc;
    logic [1:0]    inflight;
    logic          cap_valid;
    logic [1:0]    cap_idx;
    logic [31:0]   cap_pc;
    logic [23:0]   partial;
    logic          issue0;
    logic          push;
    logic          pop;
    logic          room;
    logic [CW-1:0] count;
    logic [RW-1:0] reserved_next;
    entry_t        word;
    entry_t        head;

    assign mem_req  = state == FETCH;
    assign mem_addr = mem_req ? fetch_pc[ADDR_W-1:0] + ADDR_W'(byte_cnt) : '0;
    assign issue0   = mem_req && byte_cnt == 2'd0;
    assign push     = cap_valid && cap_idx == 2'd3;
    assign pop      = inst_valid && inst_ready;
    assign word     = {cap_pc, partial, mem_rdata};

    // Slots reserved after this edge: queued words plus words already started, a push only moves one between the two
    assign reserved_next = RW'(count) + RW'(inflight) + RW'(issue0) - RW'(pop);
    assign room          = reserved_next < RW'(DEPTH);

    // Issue FSM: one byte request per cycle, a new word starts only when a queue slot can be reserved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STALL;
            byte_cnt <= 2'd0;
            fetch_pc <= RESET_PC;
            inflight <= 2'd0;
        end else if (redirect_valid) begin
            state    <= FETCH;
            byte_cnt <= 2'd0;
            fetch_pc <= redirect_pc;
            inflight <= 2'd0;
        end else begin
            inflight <= inflight + 2'(issue0) - 2'(push);
            if (state == FETCH) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    state    <= room ? FETCH : STALL;
                end
            end else if (room) begin
                state <= FETCH;
            end
        end
    end

    // Capture path: read data arrives the cycle after its request and is shifted in big-endian order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_idx   <= 2'd0;
            cap_pc    <= 32'd0;
            partial   <= 24'd0;
        end else begin
            cap_valid <= mem_req && !redirect_valid;
            cap_idx   <= byte_cnt;
            cap_pc    <= fetch_pc;
            if (cap_valid)
                partial <= {partial[15:0], mem_rdata};
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .din  (word),
        .valid(inst_valid),
        .dout (head),
        .count(count)
    );

    assign inst_data = head.inst;
    assign inst_pc   = head.pc;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed and randomized checks of the fetch unit against a word-level reference model
module tb_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        mem_req;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic [7:0]  mem [32];
    int          vectors = 0;
    int          errs = 0;
    int          nxfer = 0;
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] hold_pc = 32'd0;
    logic [31:0] hold_data = 32'd0;
    logic        hold = 1'b0;
    logic        found;
    int          n0;

    imem_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: data for a request appears the following cycle
    always @(posedge clk) begin
        if (mem_req)
            mem_rdata <= mem[mem_addr];
    end

    // Reference word: four bytes from pc upward, first byte most significant, addresses wrapping at 32
    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++)
            w = {w[23:0], mem[5'((pc + 32'(i)) % 32)]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle at the consumer: stability while held, scoreboard on transfers, then advance to the next negedge
    task automatic cycle();
        if (hold) begin
            chk("hold_valid", 64'(inst_valid), 64'd1);
            chk("hold_pc", 64'(inst_pc), 64'(hold_pc));
            chk("hold_data", 64'(inst_data), 64'(hold_data));
        end
        if (inst_valid && inst_ready) begin
            chk("xfer_pc", 64'(inst_pc), 64'(exp_pc));
            chk("xfer_data", 64'(inst_data), 64'(exp_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            nxfer++;
        end
        hold      = inst_valid && !inst_ready;
        hold_pc   = inst_pc;
        hold_data = inst_data;
        @(negedge clk);
    endtask

    // Called at the first negedge after a restart edge: byte addresses, empty queue, word valid five cycles later
    task automatic check_start(input logic [31:0] pc);
        hold = 1'b0;
        chk("start_empty", 64'(inst_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("start_req", 64'(mem_req), 64'd1);
            chk("start_addr", 64'(mem_addr), 64'((pc + 32'(k)) % 32));
            @(negedge clk);
        end
        chk("start_not_yet", 64'(inst_valid), 64'd0);
        @(negedge clk);
        chk("start_valid", 64'(inst_valid), 64'd1);
        chk("start_pc", 64'(inst_pc), 64'(pc));
        chk("start_data", 64'(inst_data), 64'(exp_word(pc)));
        exp_pc = pc;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        if (inst_valid && inst_ready) begin
            chk("redir_xfer_pc", 64'(inst_pc), 64'(exp_pc));
            chk("redir_xfer_data", 64'(inst_data), 64'(exp_word(exp_pc)));
            nxfer++;
        end
        hold = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_start(pc);
    endtask

    task automatic run_until(input logic [31:0] target);
        for (int i = 0; i < 60 && exp_pc != target; i++)
            cycle();
        chk("reach_pc", 64'(exp_pc), 64'(target));
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 8'($urandom);
        mem[0] = 8'h8C;
        mem[1] = 8'h01;
        mem[2] = 8'h00;
        mem[3] = 8'h04;

        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_data", 64'(inst_data), 64'd0);
        chk("rst_pc", 64'(inst_pc), 64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_start(32'h0);
        chk("first_word", 64'(inst_data), 64'h8C01_0004);

        for (int i = 0; i < 6; i++)
            cycle();
        chk("stall_req", 64'(mem_req), 64'd0);
        chk("stall_pc", 64'(inst_pc), 64'd0);
        chk("stall_data", 64'(inst_data), 64'h8C01_0004);
        inst_ready = 1'b1;
        cycle();
        chk("resume_req", 64'(mem_req), 64'd1);
        chk("resume_addr", 64'(mem_addr), 64'd8);
        run_until(32'd12);

        for (int i = 0; i < 300; i++) begin
            inst_ready = $urandom_range(0, 2) != 0;
            cycle();
        end

        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            cycle();
        n0 = nxfer;
        for (int i = 0; i < 40; i++)
            cycle();
        chk("throughput", 64'(nxfer - n0), 64'd10);

        inst_ready = 1'b0;
        redirect(32'h10);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (inst_valid && mem_req && mem_addr[1:0] == 2'd2)
                found = 1'b1;
            else
                cycle();
        end
        chk("midword_seen", 64'(found), 64'd1);
        redirect(32'h1C);
        inst_ready = 1'b1;
        run_until(32'h24);

        redirect(32'h3E);
        run_until(32'h46);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (inst_valid)
                found = 1'b1;
            else
                cycle();
        end
        chk("xfer_redir_seen", 64'(found), 64'd1);
        n0 = nxfer;
        redirect(32'h80);
        chk("xfer_redir_once", 64'(nxfer - n0), 64'd1);
        run_until(32'h88);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 30; i++) begin
                inst_ready = $urandom_range(0, 1) != 0;
                cycle();
            end
            redirect(r == 0 ? 32'hFFFF_FFFE : $urandom);
        end
        inst_ready = 1'b1;
        run_until(exp_pc + 32'd12);

        inst_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (inst_valid && mem_req && mem_addr[1:0] == 2'd1)
                found = 1'b1;
            else
                cycle();
        end
        chk("areset_setup", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_req", 64'(mem_req), 64'd0);
        chk("areset_addr", 64'(mem_addr), 64'd0);
        chk("areset_valid", 64'(inst_valid), 64'd0);
        chk("areset_data", 64'(inst_data), 64'd0);
        chk("areset_pc", 64'(inst_pc), 64'd0);
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_start(32'h0);
        inst_ready = 1'b1;
        run_until(32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
